// File: rtl/scaler_h_mc.sv
// Multi-channel horizontal downscaler with linear/nearest resampling and a right-edge flush.
// Ratio is scale_step/PIXEL_STEP (>= 1.0). Config is latched on vs_i. Pixel latency is 3 cycles.
module scaler_h_mc #(
  parameter int unsigned PIXEL_STEP  = 128,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned CH_COUNT    = 1,
  parameter int unsigned STEP_WIDTH  = 16,
  parameter int unsigned POS_WIDTH   = 24
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [STEP_WIDTH-1:0]           scale_step,
  input  logic                            mode_i,
  input  logic [CH_COUNT*PIXEL_WIDTH-1:0] di_i,
  input  logic                            de_i,
  input  logic                            hs_i,
  input  logic                            vs_i,
  output logic [CH_COUNT*PIXEL_WIDTH-1:0] do_o,
  output logic                            de_o,
  output logic                            hs_o,
  output logic                            vs_o
);

  localparam int unsigned FRAC_W = $clog2(PIXEL_STEP);
  localparam int unsigned IDX_W  = POS_WIDTH - FRAC_W;
  localparam int unsigned DATA_W = CH_COUNT * PIXEL_WIDTH;
  localparam int unsigned MUL_W  = PIXEL_WIDTH + FRAC_W + 1;
  localparam int unsigned W0_W   = FRAC_W + 1;

  // Configuration latched at frame start
  logic [STEP_WIDTH-1:0] step_q;
  logic                  mode_q;

  // Line state
  logic [POS_WIDTH-1:0]  pos_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  line_active_q;
  logic [DATA_W-1:0]     p_prev_q;

  // Stage 1: selected pixel pair and weight
  logic                  s1_valid_q;
  logic [DATA_W-1:0]     s1_p0_q;
  logic [DATA_W-1:0]     s1_p1_q;
  logic [FRAC_W-1:0]     s1_f_q;
  logic                  s1_mode_q;

  // Stage 2: resampled pixel
  logic                  s2_valid_q;
  logic [DATA_W-1:0]     s2_res_q;

  logic [3:0]            hs_dly_q;
  logic [3:0]            vs_dly_q;

  logic [IDX_W-1:0]      pint;
  logic [FRAC_W-1:0]     f;
  logic [IDX_W-1:0]      idx_m1;
  logic                  line_start;
  logic                  hit;
  logic                  emit;
  logic                  flush;
  logic [STEP_WIDTH-1:0] step_lat;
  logic [DATA_W-1:0]     res_c;

  always_comb begin
    pint       = IDX_W'(pos_q >> FRAC_W);
    f          = FRAC_W'(pos_q);
    idx_m1     = idx_q - IDX_W'(1);
    line_start = hs_i | vs_i;
    hit        = (pint == idx_m1);
    emit       = de_i && !line_start && (idx_q != '0) && hit;
    // Edge replicate: emit the pending position if it still falls on the last input pixel
    flush      = line_start && line_active_q && hit;
    step_lat   = (scale_step < STEP_WIDTH'(PIXEL_STEP)) ? STEP_WIDTH'(PIXEL_STEP) : scale_step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q        <= STEP_WIDTH'(PIXEL_STEP);
      mode_q        <= 1'b0;
      pos_q         <= '0;
      idx_q         <= '0;
      line_active_q <= 1'b0;
      p_prev_q      <= '0;
    end else begin
      if (vs_i) begin
        step_q <= step_lat;
        mode_q <= mode_i;
      end
      if (line_start) begin
        pos_q         <= '0;
        idx_q         <= '0;
        line_active_q <= 1'b0;
      end else if (de_i) begin
        p_prev_q      <= di_i;
        idx_q         <= idx_q + IDX_W'(1);
        line_active_q <= 1'b1;
        if (emit) begin
          pos_q <= pos_q + POS_WIDTH'(step_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_p0_q    <= '0;
      s1_p1_q    <= '0;
      s1_f_q     <= '0;
      s1_mode_q  <= 1'b0;
    end else begin
      s1_valid_q <= emit | flush;
      if (emit | flush) begin
        s1_p0_q   <= p_prev_q;
        s1_p1_q   <= flush ? p_prev_q : di_i;
        s1_f_q    <= f;
        s1_mode_q <= mode_q;
      end
    end
  end

  always_comb begin
    logic [PIXEL_WIDTH-1:0] p0;
    logic [PIXEL_WIDTH-1:0] p1;
    logic [W0_W-1:0]        w0;
    logic [MUL_W-1:0]       acc;
    logic [PIXEL_WIDTH-1:0] lin;
    res_c = '0;
    for (int c = 0; c < int'(CH_COUNT); c++) begin
      p0  = s1_p0_q[c*PIXEL_WIDTH +: PIXEL_WIDTH];
      p1  = s1_p1_q[c*PIXEL_WIDTH +: PIXEL_WIDTH];
      w0  = W0_W'(PIXEL_STEP) - W0_W'(s1_f_q);
      acc = MUL_W'(p0) * MUL_W'(w0) + MUL_W'(p1) * MUL_W'(s1_f_q) + MUL_W'(PIXEL_STEP / 2);
      lin = PIXEL_WIDTH'(acc >> FRAC_W);
      // Top fraction bit set means f >= PIXEL_STEP/2
      res_c[c*PIXEL_WIDTH +: PIXEL_WIDTH] = s1_mode_q ? (s1_f_q[FRAC_W-1] ? p1 : p0) : lin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      de_o       <= 1'b0;
      do_o       <= '0;
      hs_dly_q   <= '0;
      vs_dly_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_res_q <= res_c;
      end
      de_o <= s2_valid_q;
      if (s2_valid_q) begin
        do_o <= s2_res_q;
      end
      hs_dly_q <= {hs_dly_q[2:0], hs_i};
      vs_dly_q <= {vs_dly_q[2:0], vs_i};
    end
  end

  assign hs_o = hs_dly_q[3];
  assign vs_o = vs_dly_q[3];

endmodule

// File: tb/tb_scaler_h_mc.sv
// Directed bench for scaler_h_mc (3 channels): ratios, modes, config latching, flush,
// output latency and mid-line reset.
module tb_scaler_h_mc;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   scale_step;
  logic          mode_i;
  logic [DW-1:0] di_i;
  logic          de_i;
  logic          hs_i;
  logic          vs_i;
  logic [DW-1:0] do_o;
  logic          de_o;
  logic          hs_o;
  logic          vs_o;

  scaler_h_mc #(
    .PIXEL_STEP (128),
    .PIXEL_WIDTH(8),
    .CH_COUNT   (3),
    .STEP_WIDTH (16),
    .POS_WIDTH  (24)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scale_step(scale_step),
    .mode_i    (mode_i),
    .di_i      (di_i),
    .de_i      (de_i),
    .hs_i      (hs_i),
    .vs_i      (vs_i),
    .do_o      (do_o),
    .de_o      (de_o),
    .hs_o      (hs_o),
    .vs_o      (vs_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] q_val[$];
  int            q_t[$];
  int            hs_t[$];
  int            vs_t[$];
  int            in_t[$];
  int            stim[$];
  int            exp_q[$];
  int            hs_in;
  int            vs_in;

  always @(negedge clk) begin
    if (de_o) begin
      q_val.push_back(do_o);
      q_t.push_back(cyc);
    end
    if (hs_o) hs_t.push_back(cyc);
    if (vs_o) vs_t.push_back(cyc);
  end

  function automatic logic [31:0] rep(input int v);
    logic [7:0] b;
    b = v[7:0];
    return 32'({b, b, b});
  endfunction

  function automatic logic [31:0] qv(input int k);
    if (k < q_val.size()) return 32'(q_val[k]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] qt(input int k);
    if (k < q_t.size()) return 32'(q_t[k]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    q_val.delete();
    q_t.delete();
    hs_t.delete();
    vs_t.delete();
    in_t.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      de_i = 1'b0;
      hs_i = 1'b0;
      vs_i = 1'b0;
    end
  endtask

  task automatic pix(input logic [DW-1:0] v);
    @(negedge clk);
    di_i = v;
    de_i = 1'b1;
    hs_i = 1'b0;
    vs_i = 1'b0;
    in_t.push_back(cyc);
  endtask

  task automatic frame(input logic [15:0] step, input logic mode);
    @(negedge clk);
    de_i       = 1'b0;
    vs_i       = 1'b1;
    scale_step = step;
    mode_i     = mode;
    vs_in      = cyc;
    idle(1);
  endtask

  task automatic line_end();
    @(negedge clk);
    de_i  = 1'b0;
    hs_i  = 1'b1;
    hs_in = cyc;
    idle(7);
  endtask

  task automatic run_stim();
    foreach (stim[k]) pix(rep(stim[k]));
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_count"}, 32'(q_val.size()), 32'(exp_q.size()));
    foreach (exp_q[k]) chk($sformatf("%s_val%0d", tag, k), qv(k), rep(exp_q[k]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    scale_step = 16'd128;
    mode_i     = 1'b0;
    di_i       = '0;
    de_i       = 1'b0;
    hs_i       = 1'b0;
    vs_i       = 1'b0;
    idle(3);
    chk("rst_do", 32'(do_o), 32'd0);
    chk("rst_de", 32'(de_o), 32'd0);
    chk("rst_hs", 32'(hs_o), 32'd0);
    chk("rst_vs", 32'(vs_o), 32'd0);
    rst = 1'b0;
    idle(2);

    // 1:1 linear: widths preserved, last pixel comes from the flush
    clear_q();
    frame(16'd128, 1'b0);
    stim  = '{10, 20, 30, 40, 50, 60, 70, 80};
    run_stim();
    line_end();
    exp_q = '{10, 20, 30, 40, 50, 60, 70, 80};
    check_out("r1");
    for (int k = 0; k < 7; k++) chk($sformatf("r1_lat%0d", k), qt(k), 32'(in_t[k+1] + 3));
    chk("r1_flush_lat", qt(7), 32'(hs_in + 3));
    chk("r1_hs_lat", (hs_t.size() > 0) ? 32'(hs_t[0]) : 32'hFFFF_FFFF, 32'(hs_in + 4));
    chk("r1_vs_lat", (vs_t.size() > 0) ? 32'(vs_t[0]) : 32'hFFFF_FFFF, 32'(vs_in + 4));
    chk("r1_hold", 32'(do_o), rep(80));

    // 2:1: pending position 8 lies past the last pixel, so no flush
    clear_q();
    frame(16'd256, 1'b0);
    stim  = '{0, 20, 40, 60, 80, 100, 120, 140};
    run_stim();
    line_end();
    exp_q = '{0, 40, 80, 120};
    check_out("r2");

    // 1.5:1 linear
    clear_q();
    frame(16'd192, 1'b0);
    stim  = '{0, 100, 0, 100, 0, 100, 0, 100};
    run_stim();
    line_end();
    exp_q = '{0, 50, 100, 50, 0, 100};
    check_out("r15_lin");

    // Config changed without vs_i: must be ignored
    clear_q();
    scale_step = 16'd256;
    mode_i     = 1'b1;
    run_stim();
    line_end();
    check_out("cfg_hold");

    // 1.5:1 nearest
    clear_q();
    frame(16'd192, 1'b1);
    run_stim();
    line_end();
    exp_q = '{0, 0, 100, 100, 0, 100};
    check_out("r15_nn");

    // scale_step below unity clamps to 1:1
    clear_q();
    frame(16'd100, 1'b0);
    stim  = '{10, 20, 30, 40, 50, 60, 70, 80};
    run_stim();
    line_end();
    exp_q = '{10, 20, 30, 40, 50, 60, 70, 80};
    check_out("clamp");

    // Independent channels {ch2,ch1,ch0}, then reset mid-line
    clear_q();
    frame(16'd192, 1'b0);
    pix({8'd77, 8'd255, 8'd0});
    pix({8'd77, 8'd255, 8'd0});
    pix({8'd77, 8'd0, 8'd255});
    pix({8'd77, 8'd0, 8'd255});
    idle(5);
    chk("ch_count", 32'(q_val.size()), 32'd2);
    chk("ch_out0", qv(0), 32'({8'd77, 8'd255, 8'd0}));
    chk("ch_out1", qv(1), 32'({8'd77, 8'd128, 8'd128}));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_do", 32'(do_o), 32'd0);
    chk("midrst_de", 32'(de_o), 32'd0);
    rst = 1'b0;
    clear_q();
    line_end();
    chk("midrst_noflush", 32'(q_val.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scaler_h_mc.md
Name: scaler_h_mc

Overview:
Multi-channel horizontal downscaler with a runtime-selectable interpolation mode. It replaces the single-channel horizontal scaler in the video scaler chain. It takes a packed CH_COUNT-channel pixel stream with de/hs/vs strobes and emits a resampled stream at ratio scale_step/PIXEL_STEP (>= 1.0). It adds a right-edge flush, so a 1:1 setting preserves line width.

Parameters:
PIXEL_STEP, 128, fixed-point unit of one input pixel; power of 2; FRAC_W = log2(PIXEL_STEP)
PIXEL_WIDTH, 8, bits per channel
CH_COUNT, 1, channels packed in di_i/do_o (ch n at [n*PIXEL_WIDTH +: PIXEL_WIDTH])
STEP_WIDTH, 16, width of scale_step
POS_WIDTH, 24, width of position accumulator; must cover max_line_width*PIXEL_STEP

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
scale_step  in  STEP_WIDTH  output pixel pitch in 1/PIXEL_STEP input pixels; sampled on vs_i
mode_i  in  1  0 = linear interpolation, 1 = nearest neighbour; sampled on vs_i
di_i  in  CH_COUNT*PIXEL_WIDTH  input pixel
de_i  in  1  input pixel valid
hs_i  in  1  line-start pulse, one cycle
vs_i  in  1  frame-start pulse, one cycle; coincides with or precedes the first hs_i of the frame
do_o  out  CH_COUNT*PIXEL_WIDTH  output pixel
de_o  out  1  output pixel valid
hs_o  out  1  hs_i delayed 4 cycles
vs_o  out  1  vs_i delayed 4 cycles

Behaviour:
- Reset (rst=1 at posedge): do_o=0, de_o=0, hs_o=0, vs_o=0, pipeline cleared, step_r=PIXEL_STEP, mode_r=0, pos=0, idx=0, line_active=0. Reset wins over all other inputs in the same cycle.
- Config latch on vs_i: step_r = max(scale_step, PIXEL_STEP), so values < PIXEL_STEP clamp to 1:1. mode_r = mode_i. Config changes between vs_i pulses are ignored.
- Line state: pos (POS_WIDTH) holds the next output position; pint = pos>>FRAC_W; f = pos[FRAC_W-1:0]. idx counts input pixels in the line. p_prev holds the last input pixel.
- Per de_i=1 with input index i (idx before increment):
  - If i>=1 and pint==i-1: emit an output from p0=p_prev, p1=di_i, weight f, then pos += step_r.
  - In every case: p_prev=di_i, idx++, line_active=1.
  - Because step_r >= PIXEL_STEP, at most one emit per input pixel.
- Output arithmetic, per channel:
  - linear: out = (p0*(PIXEL_STEP-f) + p1*f + PIXEL_STEP/2) >> FRAC_W. Intermediate width PIXEL_WIDTH+FRAC_W+1; the result never exceeds 2^PIXEL_WIDTH-1.
  - nearest: out = (f >= PIXEL_STEP/2) ? p1 : p0.
- Right-edge flush on hs_i or vs_i: if line_active=1 and pint==idx-1, emit one output with p0=p1=p_prev (edge replicate). Then clear pos, idx and line_active. With line_active=0, no flush occurs.
- Latency: an emitting de_i (or a flush-triggering hs_i/vs_i) at cycle T gives de_o=1 with do_o valid at T+3. hs_i/vs_i at T gives hs_o/vs_o at T+4, so a flush pixel precedes its hs_o by exactly one cycle.
- do_o holds its last value while de_o=0.
- Input constraint: de_i=0 in the hs_i/vs_i cycle and the cycle after. Violation is undefined behaviour and need not be checked.
- Reset mid-line: the partial line is discarded with no flush; the next hs_i starts a clean line.
- pos wrap: not handled; POS_WIDTH sizing is the integrator's responsibility.
- Throughput: 1 input pixel/clk sustained; de_i gaps of any length are allowed.

Test Plan:
- 1:1: step=128, linear, CH=1, w=8, pixels 10,20,..,80, then hs_i -> 8 outputs 10..80; first 7 at T+3 of inputs 1..7; 80 one cycle before hs_o.
- 2:1: step=256, w=8, pixels 0,20,..,140 -> outputs 0,40,80,120; no flush, since pending pint=8 != 7.
- 1.5:1 linear: step=192, pixels 0,100,0,100,0,100,0,100 -> outputs 0,50,100,50,0,100; the last is the flush at pos 7.5.
- Same stream, mode_i=1 latched on vs_i -> outputs 0,0,100,100,0,100.
- Config: scale_step changed 192->256 mid-frame -> ratio stays 1.5 until next vs_i. scale_step=100 -> behaves as 128.
- CH_COUNT=3: ch0 0->255, ch1 255->0, ch2 const 77, step=192 -> output 1 = {128,128,77} (ch0,ch1,ch2), channels independent. rst asserted mid-line -> all outputs 0 next cycle; the following hs_i produces no flush.
